// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared types and helpers for the calculator command path.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int c_RADIX_MIN = 2;
    localparam int c_RADIX_MAX = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ENTRY = 2'd1,
        ST_FULL  = 2'd2
    } acc_state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_CLEAR = 3'd1,
        OP_START = 3'd2,
        OP_DIGIT = 3'd3,
        OP_BACK  = 3'd4,
        OP_NEG   = 3'd5
    } op_t;

    function automatic int calc_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic radix_legal(input int radix);
        return (radix >= c_RADIX_MIN) && (radix <= c_RADIX_MAX);
    endfunction

    // Only the highest-priority request survives a cycle.
    function automatic op_t op_select(input logic clear, input logic start,
                                      input logic digit, input logic back,
                                      input logic neg);
        if (clear)      return OP_CLEAR;
        else if (start) return OP_START;
        else if (digit) return OP_DIGIT;
        else if (back)  return OP_BACK;
        else if (neg)   return OP_NEG;
        return OP_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/d_flip_flop.sv
`default_nettype none
// ============================================================================
// Module      : d_flip_flop
// Description : Enabled D register with asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module d_flip_flop #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : operand_accumulator
// Description : Keypad digit-entry operand builder with delayed output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_accumulator
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int RADIX      = 10,
    parameter int MAX_DIGITS = 4,
    parameter int DIGIT_W    = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DIGIT_W-1:0]                    digit_in,
    input  logic                                  start,
    input  logic                                  digit_valid,
    input  logic                                  backspace,
    input  logic                                  negate,
    input  logic                                  clear,
    input  logic                                  commit,
    output logic [WIDTH-1:0]                      out_mag,
    output logic                                  out_neg,
    output logic                                  out_valid,
    output logic [calc_clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic                                  err
);

    localparam int                 c_CNT_W    = calc_clog2(MAX_DIGITS + 1);
    localparam int                 c_ARITH_W  = WIDTH + DIGIT_W + calc_clog2(RADIX);
    localparam logic [DIGIT_W:0]   c_RADIX_D  = (DIGIT_W + 1)'(RADIX);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(MAX_DIGITS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam acc_state_t         c_START_ST = (MAX_DIGITS == 1) ? ST_FULL : ST_ENTRY;

    generate
        if (!radix_legal(RADIX)) begin : g_bad_radix
            $error("operand_accumulator: RADIX must lie in 2..16");
        end
    endgenerate

    logic [WIDTH-1:0]   r_acc;
    logic               r_neg;
    logic [c_CNT_W-1:0] r_cnt;
    acc_state_t         r_state;
    logic               r_err;

    logic [WIDTH-1:0]   w_nxt_acc;
    logic               w_nxt_neg;
    logic [c_CNT_W-1:0] w_nxt_cnt;
    acc_state_t         w_nxt_state;
    logic               w_accept;
    logic               w_err;

    op_t                w_op;
    logic               w_do_start;
    logic               w_digit_bad;
    logic               w_overflow;
    logic [c_ARITH_W-1:0] w_prod;
    logic [c_CNT_W-1:0] w_cnt_inc;

    assign w_op        = op_select(clear, start, digit_valid, backspace, negate);
    assign w_do_start  = (w_op == OP_START) || ((w_op == OP_DIGIT) && (r_state == ST_EMPTY));
    assign w_digit_bad = ({1'b0, digit_in} >= c_RADIX_D);
    // Widened so the overflow bits are visible before truncating to WIDTH.
    assign w_prod      = c_ARITH_W'(r_acc) * c_ARITH_W'(RADIX) + c_ARITH_W'(digit_in);
    assign w_overflow  = |w_prod[c_ARITH_W-1:WIDTH];
    assign w_cnt_inc   = r_cnt + c_CNT_ONE;

    always_comb begin
        w_nxt_acc   = r_acc;
        w_nxt_neg   = r_neg;
        w_nxt_cnt   = r_cnt;
        w_nxt_state = r_state;
        w_accept    = 1'b0;
        w_err       = 1'b0;
        case (w_op)
            OP_CLEAR: begin
                w_nxt_acc   = '0;
                w_nxt_neg   = 1'b0;
                w_nxt_cnt   = '0;
                w_nxt_state = ST_EMPTY;
                w_accept    = 1'b1;
            end
            OP_START, OP_DIGIT: begin
                if (w_digit_bad) begin
                    w_err = 1'b1;
                end else if (w_do_start) begin
                    w_nxt_acc   = WIDTH'(digit_in);
                    w_nxt_neg   = 1'b0;
                    w_nxt_cnt   = c_CNT_ONE;
                    w_nxt_state = c_START_ST;
                    w_accept    = 1'b1;
                end else if ((r_state == ST_FULL) || w_overflow) begin
                    w_err = 1'b1;
                end else begin
                    w_nxt_acc   = w_prod[WIDTH-1:0];
                    w_nxt_cnt   = w_cnt_inc;
                    w_nxt_state = (w_cnt_inc == c_CNT_MAX) ? ST_FULL : ST_ENTRY;
                    w_accept    = 1'b1;
                end
            end
            OP_BACK: begin
                if (r_state == ST_EMPTY) begin
                    w_err = 1'b1;
                end else begin
                    w_nxt_acc = r_acc / WIDTH'(RADIX);
                    w_nxt_cnt = r_cnt - c_CNT_ONE;
                    w_accept  = 1'b1;
                    if (r_cnt == c_CNT_ONE) begin
                        w_nxt_state = ST_EMPTY;
                        w_nxt_neg   = 1'b0;
                    end else begin
                        w_nxt_state = ST_ENTRY;
                    end
                end
            end
            OP_NEG: begin
                if (r_state != ST_EMPTY) begin
                    w_nxt_neg = ~r_neg;
                    w_accept  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc   <= '0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_EMPTY;
            r_err   <= 1'b0;
        end else begin
            r_acc   <= w_nxt_acc;
            r_neg   <= w_nxt_neg;
            r_cnt   <= w_nxt_cnt;
            r_state <= w_nxt_state;
            r_err   <= w_err;
        end
    end

    // Accept and commit travel the same depth so out_valid lines up with out_mag.
    logic [1:0]     r_upd_pipe;
    logic [2:0]     r_commit_pipe;
    logic [WIDTH:0] r_out_q;

    d_flip_flop #(.WIDTH(2)) u_upd_pipe (
        .clk  (clk),
        .rst  (rst),
        .i_en (1'b1),
        .i_d  ({r_upd_pipe[0], w_accept}),
        .o_q  (r_upd_pipe)
    );

    d_flip_flop #(.WIDTH(3)) u_commit_pipe (
        .clk  (clk),
        .rst  (rst),
        .i_en (1'b1),
        .i_d  ({r_commit_pipe[1:0], commit}),
        .o_q  (r_commit_pipe)
    );

    d_flip_flop #(.WIDTH(WIDTH + 1)) u_out_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (r_upd_pipe[1]),
        .i_d  ({r_neg, r_acc}),
        .o_q  (r_out_q)
    );

    assign out_mag     = r_out_q[WIDTH-1:0];
    assign out_neg     = r_out_q[WIDTH];
    assign out_valid   = r_commit_pipe[2];
    assign digit_count = r_cnt;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_operand_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_accumulator
// Description : Three parameter sets driven in lockstep against a value model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_accumulator;

    logic       clk;
    logic       rst;
    logic [3:0] digit_in;
    logic       start, digit_valid, backspace, negate, clear, commit;

    logic [15:0] mag0;
    logic [7:0]  mag1, mag2;
    logic [2:0]  neg_o, val_o, err_o;
    logic [2:0]  cnt0, cnt1;
    logic [1:0]  cnt2;

    int total = 0;
    int bad   = 0;

    // Configurations: decimal 16-bit, decimal 8-bit, hex 8-bit with 2 digits.
    int cfg_w [3] = '{16, 8, 8};
    int cfg_r [3] = '{10, 10, 16};
    int cfg_m [3] = '{4, 4, 2};

    longint m_val  [3];
    bit     m_neg  [3];
    int     m_cnt  [3];
    longint m_omag [3];
    bit     m_oneg [3];
    bit     m_a1   [3];
    bit     m_a2   [3];
    bit     m_err  [3];
    bit     m_c1, m_c2, m_valid;

    operand_accumulator #(.WIDTH(16), .RADIX(10), .MAX_DIGITS(4), .DIGIT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .digit_in(digit_in), .start(start),
        .digit_valid(digit_valid), .backspace(backspace), .negate(negate),
        .clear(clear), .commit(commit), .out_mag(mag0), .out_neg(neg_o[0]),
        .out_valid(val_o[0]), .digit_count(cnt0), .err(err_o[0]));

    operand_accumulator #(.WIDTH(8), .RADIX(10), .MAX_DIGITS(4), .DIGIT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .digit_in(digit_in), .start(start),
        .digit_valid(digit_valid), .backspace(backspace), .negate(negate),
        .clear(clear), .commit(commit), .out_mag(mag1), .out_neg(neg_o[1]),
        .out_valid(val_o[1]), .digit_count(cnt1), .err(err_o[1]));

    operand_accumulator #(.WIDTH(8), .RADIX(16), .MAX_DIGITS(2), .DIGIT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .digit_in(digit_in), .start(start),
        .digit_valid(digit_valid), .backspace(backspace), .negate(negate),
        .clear(clear), .commit(commit), .out_mag(mag2), .out_neg(neg_o[2]),
        .out_valid(val_o[2]), .digit_count(cnt2), .err(err_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mag_of(input int i);
        case (i)
            0:       return 32'(mag0);
            1:       return 32'(mag1);
            default: return 32'(mag2);
        endcase
    endfunction

    function automatic logic [31:0] cnt_of(input int i);
        case (i)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_val[i] = 0; m_neg[i] = 0; m_cnt[i] = 0;
            m_omag[i] = 0; m_oneg[i] = 0;
            m_a1[i] = 0; m_a2[i] = 0; m_err[i] = 0;
        end
        m_c1 = 0; m_c2 = 0; m_valid = 0;
    endtask

    // Operand value kept as plain integer; entry state is implied by digit count.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit     ok;
            bit     e;
            longint nv;
            int     d;
            ok = 0; e = 0;
            d  = int'(digit_in);
            if (m_a2[i]) begin
                m_omag[i] = m_val[i];
                m_oneg[i] = m_neg[i];
            end
            if (clear) begin
                m_val[i] = 0; m_neg[i] = 0; m_cnt[i] = 0; ok = 1;
            end else if (start || (digit_valid && m_cnt[i] == 0)) begin
                if (d >= cfg_r[i]) e = 1;
                else begin
                    m_val[i] = d; m_neg[i] = 0; m_cnt[i] = 1; ok = 1;
                end
            end else if (digit_valid) begin
                nv = m_val[i] * cfg_r[i] + d;
                if (m_cnt[i] == cfg_m[i] || d >= cfg_r[i] || nv >= (64'd1 << cfg_w[i])) e = 1;
                else begin
                    m_val[i] = nv; m_cnt[i]++; ok = 1;
                end
            end else if (backspace) begin
                if (m_cnt[i] == 0) e = 1;
                else begin
                    m_val[i] = m_val[i] / cfg_r[i];
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) m_neg[i] = 0;
                    ok = 1;
                end
            end else if (negate) begin
                if (m_cnt[i] > 0) begin
                    m_neg[i] = !m_neg[i]; ok = 1;
                end
            end
            m_a2[i] = m_a1[i];
            m_a1[i] = ok;
            m_err[i] = e;
        end
        m_valid = m_c2;
        m_c2 = m_c1;
        m_c1 = commit;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_mag", i),   mag_of(i),        32'(m_omag[i]));
            chk($sformatf("d%0d_neg", i),   32'(neg_o[i]),    32'(m_oneg[i]));
            chk($sformatf("d%0d_valid", i), 32'(val_o[i]),    32'(m_valid));
            chk($sformatf("d%0d_err", i),   32'(err_o[i]),    32'(m_err[i]));
            chk($sformatf("d%0d_cnt", i),   cnt_of(i),        32'(m_cnt[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        #1;
        compare_all();
    endtask

    task automatic op(input bit cl, input bit st, input bit dv, input bit bs,
                      input bit ng, input bit cm, input int d);
        clear = cl; start = st; digit_valid = dv; backspace = bs;
        negate = ng; commit = cm; digit_in = 4'(d);
        tick();
    endtask

    task automatic idle();
        op(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        clear = 0; start = 0; digit_valid = 0; backspace = 0;
        negate = 0; commit = 0; digit_in = 4'd0;
        model_reset();
        tick();
        tick();
        rst = 1'b1;

        // Decimal entry with commit
        op(0, 1, 0, 0, 0, 0, 1);
        op(0, 0, 1, 0, 0, 0, 2);
        op(0, 0, 1, 0, 0, 0, 3);
        op(0, 0, 0, 0, 0, 1, 0);
        idle();
        idle();
        chk("dec_mag", 32'(mag0), 32'd123);
        chk("dec_valid", 32'(val_o[0]), 32'd1);
        chk("dec_cnt", 32'(cnt0), 32'd3);

        // Digit limit and 8-bit overflow
        op(1, 0, 0, 0, 0, 0, 0);
        repeat (4) op(0, 0, 1, 0, 0, 0, 9);
        op(0, 0, 1, 0, 0, 0, 9);
        chk("lim_err", 32'(err_o[0]), 32'd1);
        chk("lim_cnt", 32'(cnt0), 32'd4);
        idle();
        idle();
        chk("lim_mag", 32'(mag0), 32'd9999);
        op(1, 0, 0, 0, 0, 0, 0);
        op(0, 0, 1, 0, 0, 0, 2);
        op(0, 0, 1, 0, 0, 0, 5);
        op(0, 0, 1, 0, 0, 0, 6);
        chk("ovf_err", 32'(err_o[1]), 32'd1);
        idle();
        idle();
        chk("ovf_mag", 32'(mag1), 32'd25);

        // Backspace and sign
        op(1, 0, 0, 0, 0, 0, 0);
        op(0, 0, 1, 0, 0, 0, 4);
        op(0, 0, 1, 0, 0, 0, 5);
        op(0, 0, 0, 0, 1, 0, 0);
        op(0, 0, 0, 1, 0, 0, 0);
        idle();
        idle();
        chk("bs_mag", 32'(mag0), 32'd4);
        chk("bs_neg", 32'(neg_o[0]), 32'd1);
        op(0, 0, 0, 1, 0, 0, 0);
        idle();
        idle();
        chk("bs_empty_cnt", 32'(cnt0), 32'd0);
        chk("bs_empty_neg", 32'(neg_o[0]), 32'd0);
        op(0, 0, 0, 1, 0, 0, 0);
        chk("bs_empty_err", 32'(err_o[0]), 32'd1);

        // Radix 16 and illegal digit
        op(1, 0, 0, 0, 0, 0, 0);
        op(0, 1, 0, 0, 0, 0, 10);
        chk("hexA_dec_err", 32'(err_o[0]), 32'd1);
        op(0, 0, 1, 0, 0, 0, 15);
        op(0, 0, 0, 0, 0, 1, 0);
        idle();
        idle();
        chk("hex_mag", 32'(mag2), 32'hAF);
        chk("hex_valid", 32'(val_o[2]), 32'd1);
        op(0, 1, 0, 0, 0, 0, 3);
        op(0, 0, 1, 0, 0, 0, 15);
        chk("badF_err", 32'(err_o[0]), 32'd1);
        chk("badF_cnt", 32'(cnt0), 32'd1);

        // Priority
        op(1, 1, 1, 0, 0, 0, 5);
        chk("pri_clear_cnt", 32'(cnt0), 32'd0);
        op(0, 1, 0, 1, 0, 0, 7);
        chk("pri_start_cnt", 32'(cnt0), 32'd1);
        chk("pri_start_err", 32'(err_o[0]), 32'd0);

        // Commit together with clear
        op(0, 0, 1, 0, 0, 0, 8);
        op(1, 0, 0, 0, 0, 1, 0);
        idle();
        idle();
        chk("cc_valid", 32'(val_o[0]), 32'd1);
        chk("cc_mag", 32'(mag0), 32'd0);

        // Asynchronous reset between edges during entry
        op(0, 1, 0, 0, 0, 0, 6);
        op(0, 0, 1, 0, 0, 0, 2);
        op(0, 0, 0, 0, 0, 1, 0);
        clear = 0; start = 0; digit_valid = 0; backspace = 0; negate = 0; commit = 0;
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        #3;
        rst = 1'b1;
        op(0, 0, 1, 0, 0, 0, 4);
        op(0, 0, 1, 0, 0, 0, 2);
        idle();
        idle();
        chk("rst_resume_mag", 32'(mag0), 32'd42);
        chk("rst_resume_cnt", 32'(cnt0), 32'd2);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            op($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 1) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
               int'($urandom_range(0, 15)));
        end
        idle();
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
